regfile_mp: RTL

- Parametrised multi-port register file; next generation of the 8x16 two-read/one-write datapath register file.
- Sits between decode and writeback in the 16-bit MIPS pipeline.
- Adds configurable width, depth and port counts, an optional hard-wired zero register, and a per-register pending (scoreboard) bit for multi-cycle results.
- Decode reserves a destination; writeback clears it.

---
 rtl/regfile_pkg.sv | 24 ++
 rtl/regfile_scoreboard.sv | 67 ++++++
 rtl/regfile_mp.sv | 109 ++++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the multi-port register file.
package regfile_pkg;

    localparam int unsigned DATA_W_DEF   = 16;
    localparam int unsigned NUM_REGS_DEF = 8;
    localparam int unsigned ADDR_W_DEF   = 3;

    // Index of the hard-wired zero register when that option is enabled.
    localparam int unsigned ZERO_IDX = 0;

    // Ceiling log2; clog2(1) = 0.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned res;
        int unsigned v;
        res = 0;
        v   = (value > 0) ? value - 1 : 0;
        while (v > 0) begin
            res = res + 1;
            v   = v >> 1;
        end
        return res;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending (scoreboard) flags for the register file: decode reserves a
// destination, writeback clears it. Set beats clear on the same register.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int unsigned NUM_REGS = NUM_REGS_DEF,
    parameter int unsigned ADDR_W   = ADDR_W_DEF,
    parameter int unsigned NUM_WR   = 1,
    parameter int unsigned ZERO_REG = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_WR-1:0]        wr_valid,
    input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
    input  logic                     rsv_en,
    input  logic [ADDR_W-1:0]        rsv_addr,
    output logic                     rsv_ok,
    output logic [NUM_REGS-1:0]      pending
);

    logic [NUM_REGS-1:0] pending_q;
    logic [NUM_REGS-1:0] pending_d;
    logic                rsv_legal;
    logic                rsv_busy;
    logic                rsv_set;

    // Accept a reservation only for a legal, currently idle register.
    always_comb begin
        rsv_busy = 1'b0;
        for (int unsigned r = 0; r < NUM_REGS; r++) begin
            if (32'(rsv_addr) == r) begin
                rsv_busy = pending_q[r];
            end
        end
        rsv_legal = 32'(rsv_addr) < NUM_REGS;
        rsv_ok    = rsv_en & rsv_legal & ~rsv_busy;
        // The zero register accepts the request but never records it.
        rsv_set   = rsv_ok & ~((ZERO_REG != 0) && (32'(rsv_addr) == ZERO_IDX));
    end

    // Per-register next state: any valid write clears, an accepted reservation sets.
    always_comb begin
        pending_d = pending_q;
        for (int unsigned r = 0; r < NUM_REGS; r++) begin
            for (int unsigned w = 0; w < NUM_WR; w++) begin
                if (wr_valid[w] && (32'(wr_addr[w*ADDR_W +: ADDR_W]) == r)) begin
                    pending_d[r] = 1'b0;
                end
            end
            if (rsv_set && (32'(rsv_addr) == r)) begin
                pending_d[r] = 1'b1;
            end
        end
    end

    // Pending flag register with synchronous active-low clear.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    assign pending = pending_q;

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-port register file with per-register pending flags.
// Optional REGFILE_BYPASS_EN: same-cycle write-to-read forwarding.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W   = DATA_W_DEF,
    parameter int unsigned NUM_REGS = NUM_REGS_DEF,
    parameter int unsigned ADDR_W   = ADDR_W_DEF,
    parameter int unsigned NUM_RD   = 2,
    parameter int unsigned NUM_WR   = 1,
    parameter int unsigned ZERO_REG = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic [NUM_WR-1:0]        wr_en,
    input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
    input  logic [NUM_WR*DATA_W-1:0] wr_data,
    input  logic                     rsv_en,
    input  logic [ADDR_W-1:0]        rsv_addr,
    output logic                     rsv_ok,
    output logic [NUM_REGS-1:0]      pending
);

    if (ADDR_W < clog2(NUM_REGS)) begin : g_bad_addr_w
        $error("ADDR_W too small for NUM_REGS");
    end

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];
    logic [NUM_WR-1:0] wr_valid;

    // A write lands only for a legal address that is not the hard-wired zero.
    always_comb begin
        wr_valid = '0;
        for (int unsigned w = 0; w < NUM_WR; w++) begin
            wr_valid[w] = wr_en[w]
                && (32'(wr_addr[w*ADDR_W +: ADDR_W]) < NUM_REGS)
                && !((ZERO_REG != 0) && (32'(wr_addr[w*ADDR_W +: ADDR_W]) == ZERO_IDX));
        end
    end

    // Write merge; later ports overwrite earlier ones on an address clash.
    always_comb begin
        for (int unsigned r = 0; r < NUM_REGS; r++) begin
            regs_d[r] = regs_q[r];
            for (int unsigned w = 0; w < NUM_WR; w++) begin
                if (wr_valid[w] && (32'(wr_addr[w*ADDR_W +: ADDR_W]) == r)) begin
                    regs_d[r] = wr_data[w*DATA_W +: DATA_W];
                end
            end
        end
    end

    // Register storage with synchronous active-low clear.
    always_ff @(posedge clk) begin
        for (int unsigned r = 0; r < NUM_REGS; r++) begin
            if (!rst) begin
                regs_q[r] <= '0;
            end else begin
                regs_q[r] <= regs_d[r];
            end
        end
    end

    regfile_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W),
        .NUM_WR   (NUM_WR),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .wr_valid (wr_valid),
        .wr_addr  (wr_addr),
        .rsv_en   (rsv_en),
        .rsv_addr (rsv_addr),
        .rsv_ok   (rsv_ok),
        .pending  (pending)
    );

    // Combinational read ports; illegal and zero-register addresses read 0/idle.
    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        for (int unsigned k = 0; k < NUM_RD; k++) begin
            for (int unsigned r = 0; r < NUM_REGS; r++) begin
                if ((32'(rd_addr[k*ADDR_W +: ADDR_W]) == r)
                    && !((ZERO_REG != 0) && (r == ZERO_IDX))) begin
                    rd_data[k*DATA_W +: DATA_W] = regs_q[r];
                    rd_busy[k]                  = pending[r];
                end
            end
`ifdef REGFILE_BYPASS_EN
            // wr_valid already excludes the zero register, so it keeps reading 0.
            for (int unsigned w = 0; w < NUM_WR; w++) begin
                if (wr_valid[w]
                    && (wr_addr[w*ADDR_W +: ADDR_W] == rd_addr[k*ADDR_W +: ADDR_W])) begin
                    rd_data[k*DATA_W +: DATA_W] = wr_data[w*DATA_W +: DATA_W];
                    rd_busy[k]                  = 1'b0;
                end
            end
`endif
        end
    end

endmodule
